// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared types and frame-layout helpers for the SPI register bank.
//   state_e   : frame parser states
//   RwWrite   : value of the leading R/W bit that marks a write
//   frame_w() : total frame length, 1 + ADDR_W + DATA_W
//   addr_lsb(): bit offset of the address field inside the assembled frame
//   rw_bit()  : bit offset of the R/W flag inside the assembled frame
package spi_reg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StData,
    StDone,
    StErr
  } state_e;

  localparam logic RwWrite = 1'b1;

  function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned rw_bit(input int unsigned addr_w, input int unsigned data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: two-flop synchroniser for one asynchronous SPI pin, with an optional
// third stage for single-cycle rise/fall detection.
//   clk_i    : system clock
//   rst_ni   : synchronous active-low reset; all stages load ResetVal
//   d_i      : asynchronous pin
//   q_o      : synchronised level (second stage)
//   rise_o   : one-cycle pulse on a synchronised 0->1 (0 when EdgeDet is 0)
//   fall_o   : one-cycle pulse on a synchronised 1->0 (0 when EdgeDet is 0)
module spi_in_sync #(
  parameter logic ResetVal = 1'b0,
  parameter bit   EdgeDet  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= ResetVal;
      s2_q <= ResetVal;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

  if (EdgeDet) begin : g_edge
    logic s3_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        s3_q <= ResetVal;
      end else begin
        s3_q <= s2_q;
      end
    end

    assign rise_o = s2_q & ~s3_q;
    assign fall_o = ~s2_q & s3_q;
  end else begin : g_no_edge
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
  end

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI Mode-0 register bank. NUM_REGS registers of DATA_W bits, written (and,
// with SPI_RD_EN defined, read) through frames of {R/W, addr[ADDR_W], data[DATA_W]}, MSB first.
// All SPI pins are resynchronised into clk; clk must run at least 6x sclk.
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset
//   ncs       : SPI chip select, active low, asynchronous
//   sclk      : SPI clock, asynchronous, idle low
//   copi      : SPI data in, sampled on sclk rise
//   cipo      : SPI data out, updated on sclk fall; 0 outside a read data phase
//   regs_out  : flat register bus, reg i at [i*DATA_W +: DATA_W]
//   wr_strobe : one-cycle pulse when a write commits
//   wr_addr   : address of the last committed write
//   frame_err : one-cycle pulse when a short or overrun frame is discarded
// Build option: define SPI_RD_EN to enable register read-back on cipo. Without it cipo is
// tied low and well-formed read frames are dropped silently.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ncs,
  input  logic                       sclk,
  input  logic                       copi,
  output logic                       cipo,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int unsigned FrameW  = frame_w(ADDR_W, DATA_W);
  localparam int unsigned AddrLsb = addr_lsb(DATA_W);
  localparam int unsigned RwBit   = rw_bit(ADDR_W, DATA_W);
  localparam int unsigned CmdBits = 1 + ADDR_W;
  localparam int unsigned CntW    = $clog2(FrameW + 1);

  // Synchronised pins
  logic ncs_s, ncs_rise, ncs_fall;
  logic sclk_unused_level, sclk_rise, sclk_fall;
  logic copi_s, unused_copi_rise, unused_copi_fall;

  spi_in_sync #(
    .ResetVal (1'b1),
    .EdgeDet  (1'b1)
  ) u_sync_ncs (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (ncs),
    .q_o    (ncs_s),
    .rise_o (ncs_rise),
    .fall_o (ncs_fall)
  );

  spi_in_sync #(
    .ResetVal (1'b0),
    .EdgeDet  (1'b1)
  ) u_sync_sclk (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (sclk),
    .q_o    (sclk_unused_level),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_in_sync #(
    .ResetVal (1'b0),
    .EdgeDet  (1'b0)
  ) u_sync_copi (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (copi),
    .q_o    (copi_s),
    .rise_o (unused_copi_rise),
    .fall_o (unused_copi_fall)
  );

  // Parser state
  state_e                      state_q, state_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [FrameW-1:0]           shift_q, shift_d;
  logic [NUM_REGS*DATA_W-1:0]  regs_q, regs_d;
  logic [ADDR_W-1:0]           wr_addr_q, wr_addr_d;
  logic                        wr_strobe_q, wr_strobe_d;
  logic                        frame_err_q, frame_err_d;

  logic [FrameW-1:0]           shift_in;
  logic [CntW-1:0]             cnt_inc;
  logic                        f_rw;
  logic [ADDR_W-1:0]           f_addr;
  logic [DATA_W-1:0]           f_data;
  logic                        addr_hit;
  logic [NUM_REGS*DATA_W-1:0]  regs_wr;

  assign shift_in = {shift_q[FrameW-2:0], copi_s};
  assign cnt_inc  = cnt_q + CntW'(1);
  assign f_rw     = shift_q[RwBit];
  assign f_addr   = shift_q[AddrLsb +: ADDR_W];
  assign f_data   = shift_q[DATA_W-1:0];

  // Address decode for the frame held in the shift register; out-of-range addresses miss.
  always_comb begin
    addr_hit = 1'b0;
    regs_wr  = regs_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (f_addr == ADDR_W'(i)) begin
        addr_hit                     = 1'b1;
        regs_wr[i*DATA_W +: DATA_W]  = f_data;
      end
    end
  end

`ifdef SPI_RD_EN
  logic              rd_pend_q, rd_pend_d;  // read armed, waiting for first data-phase fall
  logic              rd_act_q, rd_act_d;    // read data being shifted out
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              cipo_q, cipo_d;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_q == ADDR_W'(i)) begin
        rd_data = regs_q[i*DATA_W +: DATA_W];
      end
    end
  end

  assign cipo = cipo_q;
`else
  logic unused_sclk_fall;
  assign unused_sclk_fall = sclk_fall;
  assign cipo             = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    regs_d      = regs_q;
    wr_addr_d   = wr_addr_q;
    wr_strobe_d = 1'b0;
    frame_err_d = 1'b0;
`ifdef SPI_RD_EN
    rd_pend_d   = rd_pend_q;
    rd_act_d    = rd_act_q;
    rd_addr_d   = rd_addr_q;
    tx_d        = tx_q;
    cipo_d      = cipo_q;
`endif

    if (ncs_rise) begin
      // Frame end takes priority over any sclk edge seen in the same cycle.
      state_d = StIdle;
`ifdef SPI_RD_EN
      rd_pend_d = 1'b0;
      rd_act_d  = 1'b0;
      cipo_d    = 1'b0;
`endif
      case (state_q)
        StDone: begin
          if (f_rw == RwWrite && addr_hit) begin
            regs_d      = regs_wr;
            wr_addr_d   = f_addr;
            wr_strobe_d = 1'b1;
          end
        end
        StCmd, StData, StErr: frame_err_d = 1'b1;
        default: ;
      endcase
    end else if (ncs_fall) begin
      // Also restarts a frame if a select glitch was missed mid-frame.
      state_d = StCmd;
      cnt_d   = '0;
      shift_d = '0;
`ifdef SPI_RD_EN
      rd_pend_d = 1'b0;
      rd_act_d  = 1'b0;
      cipo_d    = 1'b0;
`endif
    end else if (!ncs_s) begin
      if (sclk_rise) begin
        case (state_q)
          StCmd: begin
            shift_d = shift_in;
            cnt_d   = cnt_inc;
            if (cnt_q == CntW'(CmdBits - 1)) begin
              state_d = StData;
`ifdef SPI_RD_EN
              if (shift_in[ADDR_W] != RwWrite) begin
                rd_pend_d = 1'b1;
                rd_addr_d = shift_in[ADDR_W-1:0];
              end
`endif
            end
          end
          StData: begin
            shift_d = shift_in;
            cnt_d   = cnt_inc;
            if (cnt_q == CntW'(FrameW - 1)) begin
              state_d = StDone;
            end
          end
          StDone:  state_d = StErr;
          default: ;
        endcase
      end
`ifdef SPI_RD_EN
      else if (sclk_fall) begin
        if (state_q == StData && rd_pend_q) begin
          rd_pend_d        = 1'b0;
          rd_act_d         = 1'b1;
          {cipo_d, tx_d}   = {rd_data, 1'b0};
        end else if (state_q == StData && rd_act_q) begin
          {cipo_d, tx_d}   = {tx_q, 1'b0};
        end else begin
          // Fall after the last data bit: release cipo.
          rd_act_d = 1'b0;
          cipo_d   = 1'b0;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      regs_q      <= '0;
      wr_addr_q   <= '0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SPI_RD_EN
      rd_pend_q   <= 1'b0;
      rd_act_q    <= 1'b0;
      rd_addr_q   <= '0;
      tx_q        <= '0;
      cipo_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      regs_q      <= regs_d;
      wr_addr_q   <= wr_addr_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
`ifdef SPI_RD_EN
      rd_pend_q   <= rd_pend_d;
      rd_act_q    <= rd_act_d;
      rd_addr_q   <= rd_addr_d;
      tx_q        <= tx_d;
      cipo_q      <= cipo_d;
`endif
    end
  end

  assign regs_out  = regs_q;
  assign wr_addr   = wr_addr_q;
  assign wr_strobe = wr_strobe_q;
  assign frame_err = frame_err_q;

endmodule
